mc_mi_arb: RTL

- Two-requester arbiter that shares one memory-interface (mi_*) slave port, such as the simulated or real memory controller behind mc_core.
- Typical requesters: mc_core refill/writeback traffic on m0, and a DMA or second cache on m1.
- The grant is held for one complete transaction: command, then the write-data or read-data burst.
- Only one transaction is outstanding at any time. Arbitration is round-robin.

---
 rtl/mc_mi_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mc_mi_arb.sv
`default_nettype none
// ============================================================================
// Module   : mc_mi_arb
// Brief    : Round-robin arbiter sharing one mi_* slave port between two
//            requesters, holding the grant for a whole command + data burst.
// Revision : 1.0
// ============================================================================
module mc_mi_arb #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [6:0]            m0_len,
   input  logic                  m0_rw,
   input  logic                  m0_valid,
   output logic                  m0_ready,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_wack,
   output logic                  m0_wlast,
   output logic                  m0_rstb,
   output logic                  m0_rlast,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [6:0]            m1_len,
   input  logic                  m1_rw,
   input  logic                  m1_valid,
   output logic                  m1_ready,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_wack,
   output logic                  m1_wlast,
   output logic                  m1_rstb,
   output logic                  m1_rlast,
   output logic [DATA_WIDTH-1:0] m_rdata,
   output logic [ADDR_WIDTH-1:0] mi_addr,
   output logic [6:0]            mi_len,
   output logic                  mi_rw,
   output logic                  mi_valid,
   input  logic                  mi_ready,
   output logic [DATA_WIDTH-1:0] mi_wdata,
   input  logic                  mi_wack,
   input  logic                  mi_wlast,
   input  logic [DATA_WIDTH-1:0] mi_rdata,
   input  logic                  mi_rstb,
   input  logic                  mi_rlast
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RDATA = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_gnt;
   logic   w_gnt_nxt;
   logic   r_last;
   logic   w_last_nxt;

   logic                  w_gvalid;
   logic                  w_grw;
   logic [ADDR_WIDTH-1:0] w_gaddr;
   logic [6:0]            w_glen;
   logic [DATA_WIDTH-1:0] w_gwdata;

   logic w_cmd_ready;
   logic w_wack;
   logic w_wlast;
   logic w_rstb;
   logic w_rlast;

   assign w_gvalid = r_gnt ? m1_valid : m0_valid;
   assign w_grw    = r_gnt ? m1_rw    : m0_rw;
   assign w_gaddr  = r_gnt ? m1_addr  : m0_addr;
   assign w_glen   = r_gnt ? m1_len   : m0_len;
   assign w_gwdata = r_gnt ? m1_wdata : m0_wdata;

   // last starts at 1 so that m0 wins the first tie after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_gnt   <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_last  <= w_last_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_last_nxt  = r_last;
      mi_addr     = '0;
      mi_len      = '0;
      mi_rw       = 1'b0;
      mi_valid    = 1'b0;
      mi_wdata    = '0;
      w_cmd_ready = 1'b0;
      w_wack      = 1'b0;
      w_wlast     = 1'b0;
      w_rstb      = 1'b0;
      w_rlast     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (m0_valid || m1_valid) begin
               w_state_nxt = ST_CMD;
               w_gnt_nxt   = (m0_valid && m1_valid) ? ~r_last : m1_valid;
            end
         end
         ST_CMD: begin
            mi_addr     = w_gaddr;
            mi_len      = w_glen;
            mi_rw       = w_grw;
            mi_valid    = w_gvalid;
            w_cmd_ready = mi_ready;
            // a withdrawn command abandons the grant without moving the priority
            if (!w_gvalid) begin
               w_state_nxt = ST_IDLE;
            end else if (mi_ready) begin
               w_state_nxt = w_grw ? ST_RDATA : ST_WDATA;
            end
         end
         ST_WDATA: begin
            mi_wdata = w_gwdata;
            w_wack   = mi_wack;
            w_wlast  = mi_wlast;
            if (mi_wack && mi_wlast) begin
               w_state_nxt = ST_IDLE;
               w_last_nxt  = r_gnt;
            end
         end
         ST_RDATA: begin
            w_rstb  = mi_rstb;
            w_rlast = mi_rlast;
            if (mi_rstb && mi_rlast) begin
               w_state_nxt = ST_IDLE;
               w_last_nxt  = r_gnt;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign m0_ready = w_cmd_ready & ~r_gnt;
   assign m1_ready = w_cmd_ready &  r_gnt;
   assign m0_wack  = w_wack      & ~r_gnt;
   assign m1_wack  = w_wack      &  r_gnt;
   assign m0_wlast = w_wlast     & ~r_gnt;
   assign m1_wlast = w_wlast     &  r_gnt;
   assign m0_rstb  = w_rstb      & ~r_gnt;
   assign m1_rstb  = w_rstb      &  r_gnt;
   assign m0_rlast = w_rlast     & ~r_gnt;
   assign m1_rlast = w_rlast     &  r_gnt;
   assign m_rdata  = mi_rdata;

endmodule
`default_nettype wire
